branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//   Parametrised branch resolution stage for the RV32I core: evaluates all six
//   conditional-branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU), computes target,
//   and trains a BHT of 2-bit saturating counters. Sits at end of EX. Provides
//   a combinational prediction lookup port to fetch and a registered redirect
//   to the PC mux one cycle after resolution. Keeps perf counters.
// PARAMETERS
//   XLEN         32     datapath / PC width
//   BHT_ENTRIES  64     BHT depth; power of 2, >= 2; IDX_W = log2(BHT_ENTRIES)
//   BHT_INIT     2'b01  reset value of every counter (weakly not-taken)
// PORTS
//   clk             in   1      clock, rising edge
//   rst             in   1      asynchronous reset, active-high
//   pred_pc_i       in   XLEN   fetch PC for lookup
//   pred_taken_o    out  1      MSB of BHT[pred_pc_i[IDX_W+1:2]], combinational
//   ex_valid_i      in   1      instruction in EX is valid
//   ex_flush_i      in   1      kill EX instruction this cycle
//   ex_opcode_i     in   7      opcode; branch = 7'b1100011
//   ex_funct3_i     in   3      branch condition select
//   ex_pc_i         in   XLEN   PC of EX instruction
//   ex_rs1_i        in   XLEN   operand 1
//   ex_rs2_i        in   XLEN   operand 2
//   ex_imm_i        in   XLEN   sign-extended B-immediate
//   ex_pred_taken_i in   1      prediction fetch used for this instruction
//   res_valid_o     out  1      registered: a branch resolved last cycle
//   res_taken_o     out  1      registered: actual outcome
//   res_target_o    out  XLEN   registered: ex_pc_i + ex_imm_i
//   redirect_o      out  1      registered: misprediction, PC must be replaced
//   redirect_pc_o   out  XLEN   registered: correct next PC
//   illegal_o       out  1      registered: branch opcode with funct3 010/011
//   br_count_o      out  XLEN   resolved legal branches, wraps
//   mispred_count_o out  XLEN   redirects issued, wraps
// BEHAVIOUR
//   - Reset: all outputs 0, counters 0, every BHT entry = BHT_INIT; async assert.
//   - fire = ex_valid_i & ~ex_flush_i & (ex_opcode_i == 7'b1100011).
//   - Conditions: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt;
//     111 unsigned ge. 010/011 illegal: taken=0, no BHT/counter update.
//   - Target and fall-through (pc+4) computed mod 2^XLEN; carry dropped.
//   - Latency 1: all res_*/redirect*/illegal outputs register on edge after fire;
//     when fire=0 next cycle res_valid_o=redirect_o=illegal_o=0, data held.
//   - illegal fire: res_valid_o=0, illegal_o=1, redirect_o=0.
//   - Legal fire: res_valid_o=1; redirect_o = taken != ex_pred_taken_i;
//     redirect_pc_o = taken ? target : pc+4.
//   - BHT index = ex_pc_i[IDX_W+1:2]; legal fire: taken -> ctr+1 sat at 3,
//     not taken -> ctr-1 sat at 0. Update written at same edge as outputs.
//   - Same index read and written in a cycle: pred_taken_o shows pre-update value.
//   - br_count_o +1 per legal fire; mispred_count_o +1 per redirect; wrap to 0.
//   - Flush with valid: no outputs, no updates. Reset mid-stream discards
//     pending result; BHT re-initialised.
// TESTING
//   - Reset, pred_pc_i=0x100 -> pred_taken_o=0; all outputs 0.
//   - BNE rs1=5 rs2=5 pc=0x100 imm=0x20 pred=1 -> next cycle res_taken=0,
//     redirect=1, redirect_pc=0x104, mispred_count=1.
//   - BLT rs1=0xFFFFFFFF rs2=1 -> taken; BLTU same operands -> not taken.
//   - BEQ taken at pc=0x40 three times -> counter 01->10->11->11, pred_taken_o=1
//     for pred_pc_i=0x40; lookup same cycle as 2nd update returns pre-update 1.
//   - funct3=010 valid branch -> illegal_o=1, res_valid_o=0, br_count unchanged;
//     same fire with ex_flush_i=1 -> no outputs at all.
//   - pc=0xFFFFFFF0 imm=0x20 taken -> res_target_o=0x00000010 (wrap).

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: end-of-EX branch resolver with a 2-bit-counter BHT, registered redirect and perf counters
//   clk, rst                     clock; asynchronous active-high reset
//   pred_pc_i / pred_taken_o     combinational BHT lookup for fetch
//   ex_*                         instruction in EX: valid, flush, opcode, funct3, pc, operands, imm, fetch prediction
//   res_valid/taken/target_o     registered resolution of a legal branch
//   redirect_o / redirect_pc_o   registered misprediction redirect to the PC mux
//   illegal_o                    registered: branch opcode with reserved funct3
//   br_count_o / mispred_count_o wrapping counts of legal branches and redirects
module branch_resolve_unit #(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 64,
  parameter logic [1:0] BHT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            pred_taken_o,
  input  logic            ex_valid_i,
  input  logic            ex_flush_i,
  input  logic [6:0]      ex_opcode_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_pred_taken_i,
  output logic            res_valid_o,
  output logic            res_taken_o,
  output logic [XLEN-1:0] res_target_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] br_count_o,
  output logic [XLEN-1:0] mispred_count_o
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic [1:0] bht [BHT_ENTRIES];
  logic fire, bad_f3, legal, eq, lt, ltu, taken, mispred;
  logic [XLEN-1:0] target, fall;
  logic [IDX_W-1:0] idx;
  logic [1:0] ctr, ctr_nxt;
  // lookup reads the array directly, so a same-cycle update is not yet visible
  assign pred_taken_o = bht[pred_pc_i[IDX_W+1:2]][1];
  assign fire = ex_valid_i & ~ex_flush_i & (ex_opcode_i == 7'b1100011);
  assign bad_f3 = ex_funct3_i[2:1] == 2'b01;
  assign legal = fire & ~bad_f3;
  assign eq = ex_rs1_i == ex_rs2_i;
  assign lt = $signed(ex_rs1_i) < $signed(ex_rs2_i);
  assign ltu = ex_rs1_i < ex_rs2_i;
  // funct3[0] inverts the base condition: eq/ne, lt/ge, ltu/geu
  assign taken = ~bad_f3 & ((ex_funct3_i[2] ? (ex_funct3_i[1] ? ltu : lt) : eq) ^ ex_funct3_i[0]);
  assign target = ex_pc_i + ex_imm_i;
  assign fall = ex_pc_i + XLEN'(4);
  assign mispred = legal & (taken != ex_pred_taken_i);
  assign idx = ex_pc_i[IDX_W+1:2];
  assign ctr = bht[idx];
  always_comb begin
    ctr_nxt = taken ? (ctr == 2'b11 ? ctr : ctr + 2'b01) : (ctr == 2'b00 ? ctr : ctr - 2'b01);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_INIT;
    end else if (legal) begin
      bht[idx] <= ctr_nxt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_o <= 1'b0;
      res_taken_o <= 1'b0;
      res_target_o <= '0;
      redirect_o <= 1'b0;
      redirect_pc_o <= '0;
      illegal_o <= 1'b0;
      br_count_o <= '0;
      mispred_count_o <= '0;
    end else begin
      res_valid_o <= legal;
      redirect_o <= mispred;
      illegal_o <= fire & bad_f3;
      if (fire) begin
        res_taken_o <= taken;
        res_target_o <= target;
        redirect_pc_o <= taken ? target : fall;
      end
      if (legal) br_count_o <= br_count_o + XLEN'(1);
      if (mispred) mispred_count_o <= mispred_count_o + XLEN'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic clk = 0, rst = 1;
  logic [31:0] pred_pc = 0, pc = 0, rs1 = 0, rs2 = 0, imm = 0;
  logic valid = 0, flush = 0, pred = 0;
  logic [6:0] opcode = 7'b1100011;
  logic [2:0] f3 = 0;
  logic pred_taken, res_valid, res_taken, redirect, illegal;
  logic [31:0] res_target, redirect_pc, br_count, mispred_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .pred_pc_i(pred_pc), .pred_taken_o(pred_taken),
    .ex_valid_i(valid), .ex_flush_i(flush), .ex_opcode_i(opcode), .ex_funct3_i(f3),
    .ex_pc_i(pc), .ex_rs1_i(rs1), .ex_rs2_i(rs2), .ex_imm_i(imm), .ex_pred_taken_i(pred),
    .res_valid_o(res_valid), .res_taken_o(res_taken), .res_target_o(res_target),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .illegal_o(illegal),
    .br_count_o(br_count), .mispred_count_o(mispred_count)
  );
  task automatic set_br(input logic [2:0] f, input logic [31:0] p, a, b, i, input logic pr, fl);
    valid = 1; f3 = f; pc = p; rs1 = a; rs2 = b; imm = i; pred = pr; flush = fl;
  endtask
  task automatic step;
    @(posedge clk); #1;
    valid = 0; flush = 0;
  endtask
  task automatic test_reset;
    pred_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", pred_taken); end
    checks++; if ({res_valid, res_taken, redirect, illegal} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {res_valid, res_taken, redirect, illegal}); end
    checks++; if ({res_target, redirect_pc, br_count, mispred_count} !== 128'b0) begin errors++; $display("FAIL reset_data got %h exp 0", {res_target, redirect_pc, br_count, mispred_count}); end
    rst = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_bne;
    set_br(3'b001, 32'h100, 5, 5, 32'h20, 1, 0);
    step;
    checks++; if ({res_valid, res_taken, redirect} !== 3'b101) begin errors++; $display("FAIL bne_flags got %b exp 101", {res_valid, res_taken, redirect}); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL bne_rpc got %h exp 00000104", redirect_pc); end
    checks++; if (res_target !== 32'h120) begin errors++; $display("FAIL bne_target got %h exp 00000120", res_target); end
    checks++; if ({br_count, mispred_count} !== {32'd1, 32'd1}) begin errors++; $display("FAIL bne_counts got %0d %0d exp 1 1", br_count, mispred_count); end
    step;
    checks++; if ({res_valid, redirect, illegal} !== 3'b000) begin errors++; $display("FAIL idle_flags got %b exp 000", {res_valid, redirect, illegal}); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL idle_hold got %h exp 00000104", redirect_pc); end
  endtask
  task automatic test_signed;
    set_br(3'b100, 32'h200, 32'hFFFFFFFF, 1, 8, 1, 0);
    step;
    checks++; if ({res_valid, res_taken, redirect} !== 3'b110) begin errors++; $display("FAIL blt_flags got %b exp 110", {res_valid, res_taken, redirect}); end
    checks++; if (redirect_pc !== 32'h208) begin errors++; $display("FAIL blt_rpc got %h exp 00000208", redirect_pc); end
    set_br(3'b110, 32'h200, 32'hFFFFFFFF, 1, 8, 0, 0);
    step;
    checks++; if ({res_valid, res_taken, redirect} !== 3'b100) begin errors++; $display("FAIL bltu_flags got %b exp 100", {res_valid, res_taken, redirect}); end
    checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL bltu_rpc got %h exp 00000204", redirect_pc); end
    set_br(3'b101, 32'h300, 32'hFFFFFFFF, 1, 8, 1, 0);
    step;
    checks++; if ({res_taken, redirect} !== 2'b01) begin errors++; $display("FAIL bge_flags got %b exp 01", {res_taken, redirect}); end
    set_br(3'b111, 32'h300, 32'hFFFFFFFF, 1, 8, 1, 0);
    step;
    checks++; if ({res_taken, redirect} !== 2'b10) begin errors++; $display("FAIL bgeu_flags got %b exp 10", {res_taken, redirect}); end
    checks++; if ({br_count, mispred_count} !== {32'd5, 32'd2}) begin errors++; $display("FAIL signed_counts got %0d %0d exp 5 2", br_count, mispred_count); end
  endtask
  task automatic test_bht;
    pred_pc = 32'h40;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bht_init got %b exp 0", pred_taken); end
    set_br(3'b000, 32'h40, 7, 7, 32'h10, 0, 0);
    step;
    checks++; if ({pred_taken, redirect, redirect_pc} !== {2'b11, 32'h50}) begin errors++; $display("FAIL bht_1 got %b %b %h exp 1 1 00000050", pred_taken, redirect, redirect_pc); end
    set_br(3'b000, 32'h40, 7, 7, 32'h10, 1, 0);
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL bht_bypass got %b exp 1", pred_taken); end
    step;
    set_br(3'b000, 32'h40, 7, 7, 32'h10, 1, 0);
    step;
    checks++; if ({pred_taken, redirect} !== 2'b10) begin errors++; $display("FAIL bht_sat got %b exp 10", {pred_taken, redirect}); end
    set_br(3'b001, 32'h40, 7, 7, 32'h10, 1, 0);
    step;
    checks++; if ({pred_taken, redirect} !== 2'b11) begin errors++; $display("FAIL bht_dec1 got %b exp 11", {pred_taken, redirect}); end
    set_br(3'b001, 32'h40, 7, 7, 32'h10, 0, 0);
    step;
    checks++; if ({pred_taken, redirect} !== 2'b00) begin errors++; $display("FAIL bht_dec2 got %b exp 00", {pred_taken, redirect}); end
    checks++; if ({br_count, mispred_count} !== {32'd10, 32'd4}) begin errors++; $display("FAIL bht_counts got %0d %0d exp 10 4", br_count, mispred_count); end
  endtask
  task automatic test_illegal;
    pred_pc = 32'h80;
    set_br(3'b010, 32'h80, 1, 1, 4, 1, 0);
    step;
    checks++; if ({illegal, res_valid, redirect} !== 3'b100) begin errors++; $display("FAIL illegal_flags got %b exp 100", {illegal, res_valid, redirect}); end
    checks++; if ({br_count, mispred_count} !== {32'd10, 32'd4}) begin errors++; $display("FAIL illegal_counts got %0d %0d exp 10 4", br_count, mispred_count); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL illegal_bht got %b exp 0", pred_taken); end
    set_br(3'b010, 32'h80, 1, 1, 4, 1, 1);
    step;
    checks++; if ({illegal, res_valid, redirect} !== 3'b000) begin errors++; $display("FAIL flush_illegal got %b exp 000", {illegal, res_valid, redirect}); end
    set_br(3'b000, 32'h80, 1, 1, 4, 0, 1);
    step;
    checks++; if ({illegal, res_valid, redirect, pred_taken} !== 4'b0000) begin errors++; $display("FAIL flush_legal got %b exp 0000", {illegal, res_valid, redirect, pred_taken}); end
    checks++; if ({br_count, mispred_count} !== {32'd10, 32'd4}) begin errors++; $display("FAIL flush_counts got %0d %0d exp 10 4", br_count, mispred_count); end
    opcode = 7'b0110011;
    set_br(3'b000, 32'h80, 1, 1, 4, 0, 0);
    step;
    opcode = 7'b1100011;
    checks++; if ({res_valid, redirect, br_count} !== {2'b00, 32'd10}) begin errors++; $display("FAIL nonbranch got %b %b %0d exp 0 0 10", res_valid, redirect, br_count); end
  endtask
  task automatic test_wrap;
    pred_pc = 32'hFFFFFFF0;
    set_br(3'b000, 32'hFFFFFFF0, 3, 3, 32'h20, 1, 0);
    step;
    checks++; if ({res_target, redirect_pc} !== {32'h10, 32'h10}) begin errors++; $display("FAIL wrap_target got %h %h exp 00000010 00000010", res_target, redirect_pc); end
    checks++; if ({res_valid, redirect, pred_taken} !== 3'b101) begin errors++; $display("FAIL wrap_flags got %b exp 101", {res_valid, redirect, pred_taken}); end
  endtask
  task automatic test_reset_mid;
    set_br(3'b000, 32'hFFFFFFF0, 3, 3, 32'h20, 0, 0);
    #2 rst = 1;
    #1;
    checks++; if ({res_valid, br_count, pred_taken} !== {1'b0, 32'd0, 1'b0}) begin errors++; $display("FAIL async_rst got %b %0d %b exp 0 0 0", res_valid, br_count, pred_taken); end
    step;
    checks++; if ({res_valid, redirect, mispred_count} !== {2'b00, 32'd0}) begin errors++; $display("FAIL rst_discard got %b %b %0d exp 0 0 0", res_valid, redirect, mispred_count); end
    rst = 0;
    step;
  endtask
  initial begin
    test_reset;
    test_bne;
    test_signed;
    test_bht;
    test_illegal;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
